axis_ad5791_spi: RTL and testbench

//  Four-lane SPI master for four AD5791 20-bit DACs (X, Y, Z, U) fed by AXI-Stream position words from the SPM control path.

---
 rtl/ad5791_pkg.sv | 25 ++
 rtl/ad5791_spi_shifter.sv | 91 +++++++++
 rtl/axis_ad5791_spi.sv | 190 +++++++++++++++++++
 tb/tb_axis_ad5791_spi.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad5791_pkg.sv
// ad5791_pkg
//   Shared definitions for the AD5791 four-lane SPI master: frame geometry,
//   AD5791 register addresses, the controller state encoding and the helper
//   that builds a DAC-register write word from a 20-bit code.
package ad5791_pkg;

  localparam int AD5791_FRAME_BITS = 24;
  localparam int AD5791_LANES      = 4;

  localparam logic [2:0] AD5791_ADDR_DAC  = 3'b001;
  localparam logic [2:0] AD5791_ADDR_CTRL = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } ad5791_state_t;

  // Write word: R/W_n=0 (write), 3-bit register address, 20-bit payload.
  function automatic logic [AD5791_FRAME_BITS-1:0] ad5791_dac_word(input logic [19:0] code20);
    return {1'b0, AD5791_ADDR_DAC, code20};
  endfunction

endpackage

// File: rtl/ad5791_spi_shifter.sv
// ad5791_spi_shifter
//   Four parallel-load 24-bit shift registers sharing one SCLK generator and
//   bit counter. After 'start', each bit is SCLK high for SCLK_DIV cycles then
//   low for SCLK_DIV cycles. Data advances one cycle after the SCLK falling
//   edge so SDIN is stable around the DAC sample point.
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   load         parallel load of 'words' into the lane shifters
//   words        4 x 24-bit frame words, lane 0 = X
//   start        begin shifting (first SCLK rise on the following cycle)
//   sclk         shared serial clock, idles low
//   sdin         per-lane serial data, MSB first
//   done         high in the final cycle of the last bit's low phase
module ad5791_spi_shifter
  import ad5791_pkg::*;
#(
  parameter int SCLK_DIV = 2
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             load,
  input  logic [AD5791_LANES-1:0][AD5791_FRAME_BITS-1:0]   words,
  input  logic                                             start,
  output logic                                             sclk,
  output logic [AD5791_LANES-1:0]                          sdin,
  output logic                                             done
);

  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam int BIT_W = $clog2(AD5791_FRAME_BITS);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(AD5791_FRAME_BITS - 1);

  logic [AD5791_LANES-1:0][AD5791_FRAME_BITS-1:0] sh_q;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             active;
  logic             div_tc;
  logic             shift_en;

  assign div_tc   = (div_cnt == '0);
  // First cycle of the low phase: the falling edge has just happened.
  assign shift_en = active && !sclk && (div_cnt == DIV_LAST);
  assign done     = active && !sclk && div_tc && (bit_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q    <= '0;
      sclk    <= 1'b0;
      active  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      if (load) begin
        sh_q <= words;
      end else if (shift_en) begin
        for (int i = 0; i < AD5791_LANES; i++) begin
          sh_q[i] <= {sh_q[i][AD5791_FRAME_BITS-2:0], 1'b0};
        end
      end

      if (start) begin
        active  <= 1'b1;
        sclk    <= 1'b1;
        div_cnt <= DIV_LAST;
        bit_cnt <= BIT_LAST;
      end else if (active) begin
        if (!div_tc) begin
          div_cnt <= div_cnt - 1'b1;
        end else if (sclk) begin
          sclk    <= 1'b0;
          div_cnt <= DIV_LAST;
        end else if (bit_cnt == '0) begin
          active <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt - 1'b1;
          sclk    <= 1'b1;
          div_cnt <= DIV_LAST;
        end
      end
    end
  end

  always_comb begin
    sdin = '0;
    for (int i = 0; i < AD5791_LANES; i++) begin
      sdin[i] = sh_q[i][AD5791_FRAME_BITS-1];
    end
  end

endmodule

// File: rtl/axis_ad5791_spi.sv
// axis_ad5791_spi
//   Four-lane SPI master for four AD5791 DACs (X, Y, Z, U). In stream mode the
//   latest AXI-Stream codes are written to the DAC registers back-to-back; in
//   config mode the DACs are held and a rising edge on configuration_send
//   sends one host-supplied 24-bit word per lane.
//   Optional build macro AD5791_SKIP_UNCHANGED_EN: stream frames are sent only
//   when some code differs from the last transmitted one (first frame after
//   reset always goes out).
// Ports
//   a_clk, reset              clock, asynchronous active-high reset
//   S_AXIS1..4_tdata/tvalid   X/Y/Z/U words, DAC code = tdata[31:12]
//   S_AXISCFG_tdata/tvalid    config word, tdata[23:0] is the SPI word
//   configuration_mode        1 = config/hold, 0 = stream
//   configuration_axis        config target lane 0..3; 4..7 dropped
//   configuration_send        rising edge requests a config frame
//   ready                     idle with no pending request
//   dac_sclk, dac_sync_n      shared SCLK and frame select
//   dac_sdin                  per-lane serial data, bit0 = X
//
// state | meaning
// IDLE  | waiting; chooses config or stream frame and loads the shifters
// LOAD  | SYNC_n low, MSB on all lanes
// SHIFT | 24 SCLK periods
// GAP   | SYNC_n high for SYNC_GAP cycles (DAC update on SYNC_n rise)
module axis_ad5791_spi
  import ad5791_pkg::*;
#(
  parameter int SCLK_DIV = 2,
  parameter int SYNC_GAP = 2
) (
  input  logic        a_clk,
  input  logic        reset,
  input  logic [31:0] S_AXIS1_tdata,
  input  logic        S_AXIS1_tvalid,
  input  logic [31:0] S_AXIS2_tdata,
  input  logic        S_AXIS2_tvalid,
  input  logic [31:0] S_AXIS3_tdata,
  input  logic        S_AXIS3_tvalid,
  input  logic [31:0] S_AXIS4_tdata,
  input  logic        S_AXIS4_tvalid,
  input  logic [31:0] S_AXISCFG_tdata,
  input  logic        S_AXISCFG_tvalid,
  input  logic        configuration_mode,
  input  logic [2:0]  configuration_axis,
  input  logic        configuration_send,
  output logic        ready,
  output logic        dac_sclk,
  output logic        dac_sync_n,
  output logic [3:0]  dac_sdin
);

  localparam int GAP_W = (SYNC_GAP > 1) ? $clog2(SYNC_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SYNC_GAP - 1);

  logic [31:0] tdata [AD5791_LANES];
  logic [AD5791_LANES-1:0] tvalid;
  logic [19:0] code_q [AD5791_LANES];
  logic [AD5791_FRAME_BITS-1:0] cfg_q [AD5791_LANES];
  logic unused_bits;

  always_comb begin
    tdata[0] = S_AXIS1_tdata;
    tdata[1] = S_AXIS2_tdata;
    tdata[2] = S_AXIS3_tdata;
    tdata[3] = S_AXIS4_tdata;
  end

  assign tvalid = {S_AXIS4_tvalid, S_AXIS3_tvalid, S_AXIS2_tvalid, S_AXIS1_tvalid};
  assign unused_bits = ^{S_AXIS1_tdata[11:0], S_AXIS2_tdata[11:0], S_AXIS3_tdata[11:0],
                         S_AXIS4_tdata[11:0], S_AXISCFG_tdata[31:24]};

  // Input capture; cfg writes land one cycle before a frame can load them.
  always_ff @(posedge a_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < AD5791_LANES; i++) begin
        code_q[i] <= '0;
        cfg_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < AD5791_LANES; i++) begin
        if (tvalid[i] && !configuration_mode) begin
          code_q[i] <= tdata[i][31:12];
        end
      end
      if (S_AXISCFG_tvalid && configuration_mode && !configuration_axis[2]) begin
        cfg_q[configuration_axis[1:0]] <= S_AXISCFG_tdata[AD5791_FRAME_BITS-1:0];
      end
    end
  end

  ad5791_state_t state_q, state_d;
  logic [GAP_W-1:0] gap_cnt;
  logic send_hist, send_pend, send_edge, pend_next;
  logic shift_done, stream_go;
  logic load_cfg, load_stream, load, start;
  logic sync_n_d, ready_d;
  logic [AD5791_LANES-1:0][AD5791_FRAME_BITS-1:0] words;

  assign send_edge = configuration_send & ~send_hist;

`ifdef AD5791_SKIP_UNCHANGED_EN
  logic [19:0] last_q [AD5791_LANES];
  logic sent_once;
  logic code_diff;

  always_comb begin
    code_diff = 1'b0;
    for (int i = 0; i < AD5791_LANES; i++) begin
      if (code_q[i] != last_q[i]) code_diff = 1'b1;
    end
  end

  assign stream_go = !sent_once || code_diff;

  always_ff @(posedge a_clk or posedge reset) begin
    if (reset) begin
      sent_once <= 1'b0;
      for (int i = 0; i < AD5791_LANES; i++) last_q[i] <= '0;
    end else if (load_stream) begin
      sent_once <= 1'b1;
      for (int i = 0; i < AD5791_LANES; i++) last_q[i] <= code_q[i];
    end
  end
`else
  assign stream_go = 1'b1;
`endif

  // State register plus registered outputs (no decode glitches on pins).
  always_ff @(posedge a_clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      gap_cnt    <= '0;
      send_hist  <= 1'b0;
      send_pend  <= 1'b0;
      dac_sync_n <= 1'b1;
      ready      <= 1'b1;
    end else begin
      state_q    <= state_d;
      send_hist  <= configuration_send;
      send_pend  <= pend_next;
      dac_sync_n <= sync_n_d;
      ready      <= ready_d;
      if (state_q != GAP) begin
        gap_cnt <= GAP_LAST;
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (configuration_mode ? send_pend : stream_go) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (shift_done) state_d = GAP;
      GAP:     if (gap_cnt == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_cfg    = (state_q == IDLE) && configuration_mode && send_pend;
    load_stream = (state_q == IDLE) && !configuration_mode && stream_go;
    load        = load_cfg || load_stream;
    start       = (state_q == LOAD);
    words       = '0;
    for (int i = 0; i < AD5791_LANES; i++) begin
      words[i] = load_cfg ? cfg_q[i] : ad5791_dac_word(code_q[i]);
    end
    // A fresh edge arriving while the previous request loads is kept.
    pend_next = send_edge || (send_pend && !load_cfg);
    sync_n_d  = !((state_d == LOAD) || (state_d == SHIFT));
    ready_d   = (state_d == IDLE) && !pend_next;
  end

  ad5791_spi_shifter #(
    .SCLK_DIV(SCLK_DIV)
  ) u_shifter (
    .clk   (a_clk),
    .rst   (reset),
    .load  (load),
    .words (words),
    .start (start),
    .sclk  (dac_sclk),
    .sdin  (dac_sdin),
    .done  (shift_done)
  );

endmodule

// File: tb/tb_axis_ad5791_spi.sv
module tb_axis_ad5791_spi;

  logic        a_clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] s1_tdata = '0, s2_tdata = '0, s3_tdata = '0, s4_tdata = '0;
  logic        s1_tvalid = 1'b0, s2_tvalid = 1'b0, s3_tvalid = 1'b0, s4_tvalid = 1'b0;
  logic [31:0] cfg_tdata = '0;
  logic        cfg_tvalid = 1'b0;
  logic        mode = 1'b1;
  logic [2:0]  axis = '0;
  logic        send = 1'b0;
  logic        ready, dac_sclk, dac_sync_n;
  logic [3:0]  dac_sdin;

  axis_ad5791_spi dut (
    .a_clk              (a_clk),
    .reset              (reset),
    .S_AXIS1_tdata      (s1_tdata),
    .S_AXIS1_tvalid     (s1_tvalid),
    .S_AXIS2_tdata      (s2_tdata),
    .S_AXIS2_tvalid     (s2_tvalid),
    .S_AXIS3_tdata      (s3_tdata),
    .S_AXIS3_tvalid     (s3_tvalid),
    .S_AXIS4_tdata      (s4_tdata),
    .S_AXIS4_tvalid     (s4_tvalid),
    .S_AXISCFG_tdata    (cfg_tdata),
    .S_AXISCFG_tvalid   (cfg_tvalid),
    .configuration_mode (mode),
    .configuration_axis (axis),
    .configuration_send (send),
    .ready              (ready),
    .dac_sclk           (dac_sclk),
    .dac_sync_n         (dac_sync_n),
    .dac_sdin           (dac_sdin)
  );

  always #5 a_clk = ~a_clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame monitor: reconstructs each lane word from SDIN at SCLK falling edges.
  int          cyc = 0, frame_cnt = 0, sclk_rises = 0;
  int          cur_bits = 0, cur_low = 0, last_bits = 0, last_low = 0;
  int          end_cyc = 0, prev_end = 0;
  logic [23:0] acc [4];
  logic [23:0] word [4];
  logic        prev_sclk = 1'b0, prev_sync = 1'b1;

  always @(negedge a_clk) begin
    cyc++;
    if (reset) begin
      for (int i = 0; i < 4; i++) acc[i] = '0;
      cur_bits  = 0;
      cur_low   = 0;
      prev_sclk = 1'b0;
      prev_sync = 1'b1;
    end else begin
      if (dac_sclk && !prev_sclk) sclk_rises++;
      if (!dac_sclk && prev_sclk && !dac_sync_n) begin
        for (int i = 0; i < 4; i++) acc[i] = {acc[i][22:0], dac_sdin[i]};
        cur_bits++;
      end
      if (!dac_sync_n) cur_low++;
      if (dac_sync_n && !prev_sync) begin
        for (int i = 0; i < 4; i++) begin
          word[i] = acc[i];
          acc[i]  = '0;
        end
        last_bits = cur_bits;
        last_low  = cur_low;
        prev_end  = end_cyc;
        end_cyc   = cyc;
        frame_cnt++;
        cur_bits = 0;
        cur_low  = 0;
      end
      prev_sclk = dac_sclk;
      prev_sync = dac_sync_n;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge a_clk);
      #1;
    end
  endtask

  task automatic wait_frames(input int target, input string tag);
    int k = 0;
    while (frame_cnt < target && k < 500) begin
      step();
      k++;
    end
    if (frame_cnt < target) check({tag, "_timeout"}, frame_cnt, target);
  endtask

  task automatic wait_sync(input logic lvl, input string tag);
    int k = 0;
    while (dac_sync_n !== lvl && k < 500) begin
      step();
      k++;
    end
    if (dac_sync_n !== lvl) check({tag, "_sync_timeout"}, dac_sync_n, lvl);
  endtask

  task automatic check_words(input string tag, input logic [23:0] x, input logic [23:0] y,
                             input logic [23:0] z, input logic [23:0] u);
    check({tag, "_x"}, word[0], x);
    check({tag, "_y"}, word[1], y);
    check({tag, "_z"}, word[2], z);
    check({tag, "_u"}, word[3], u);
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    axis       = a;
    cfg_tdata  = d;
    cfg_tvalid = 1'b1;
    step();
    cfg_tvalid = 1'b0;
  endtask

  initial begin
    int base;
    int n;
    int idle_bad;

    // Reset state
    step(3);
    check("rst_sync_n", dac_sync_n, 1);
    check("rst_sclk", dac_sclk, 0);
    check("rst_sdin", dac_sdin, 0);
    check("rst_ready", ready, 1);
    reset = 1'b0;

    // Config mode, no send: nothing moves for 200 cycles
    idle_bad = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (dac_sync_n !== 1'b1 || dac_sclk !== 1'b0 || ready !== 1'b1) idle_bad++;
    end
    check("idle_hold", idle_bad, 0);
    check("idle_sclk_edges", sclk_rises, 0);

    // Config frame; axis 5 write must be dropped
    cfg_write(3'd3, 32'h0000_0080);
    cfg_write(3'd2, 32'h0000_0040);
    cfg_write(3'd1, 32'h0000_0020);
    cfg_write(3'd0, 32'h0000_0010);
    cfg_write(3'd5, 32'h00FF_FFFF);
    base = frame_cnt;
    send = 1'b1;
    step();
    send = 1'b0;
    check("cfg_ready_low", ready, 0);
    wait_sync(1'b0, "cfg");
    n = 0;
    while (ready !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    check("cfg_ready_cycles", n, 99);
    check("cfg_frames", frame_cnt, base + 1);
    check("cfg_bits", last_bits, 24);
    check("cfg_sync_low", last_low, 97);
    check_words("cfg", 24'h000010, 24'h000020, 24'h000040, 24'h000080);

`ifndef AD5791_SKIP_UNCHANGED_EN
    // Stream mode, back-to-back refresh
    mode      = 1'b0;
    s1_tdata  = 32'h0040_0000;
    s1_tvalid = 1'b1;
    base      = frame_cnt;
    step();
    s1_tvalid = 1'b0;
    wait_frames(base + 2, "stream");
    check_words("stream", 24'h100400, 24'h100000, 24'h100000, 24'h100000);
    wait_frames(base + 3, "stream2");
    check("stream2_x", word[0], 24'h100400);
    check("stream_period", end_cyc - prev_end, 100);

    // Mid-frame data change takes effect next frame
    wait_sync(1'b1, "mid");
    wait_sync(1'b0, "mid");
    step(10);
    s1_tdata  = 32'h0080_0000;
    s1_tvalid = 1'b1;
    base      = frame_cnt;
    step();
    s1_tvalid = 1'b0;
    wait_frames(base + 1, "mid_old");
    check("mid_old_x", word[0], 24'h100400);
    wait_frames(base + 2, "mid_new");
    check("mid_new_x", word[0], 24'h100800);

    // Mode switch + send during a stream frame: frame completes, then config
    wait_sync(1'b1, "sw");
    wait_sync(1'b0, "sw");
    step(10);
    base = frame_cnt;
    mode = 1'b1;
    send = 1'b1;
    step();
    send = 1'b0;
    wait_frames(base + 1, "sw_stream");
    check("sw_stream_x", word[0], 24'h100800);
    check("sw_stream_y", word[1], 24'h100000);
    wait_frames(base + 2, "sw_cfg");
    check_words("sw_cfg", 24'h000010, 24'h000020, 24'h000040, 24'h000080);
    n = 0;
    while (ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("sw_ready", ready, 1);
`else
    // Skip-unchanged: constant inputs give one frame, a U change gives one more
    mode = 1'b0;
    base = frame_cnt;
    step(400);
    check("skip_first", frame_cnt, base + 1);
    s4_tdata  = 32'h1234_5000;
    s4_tvalid = 1'b1;
    step();
    s4_tvalid = 1'b0;
    step(400);
    check("skip_change", frame_cnt, base + 2);
    check("skip_u", word[3], 24'h112345);
    check("skip_x", word[0], 24'h100000);
    mode = 1'b1;
    step(5);
`endif

    // Reset mid-SHIFT aborts at once
    send = 1'b1;
    step();
    send = 1'b0;
    wait_sync(1'b0, "abort");
    step(20);
    base  = frame_cnt;
    reset = 1'b1;
    #1;
    check("abort_sync_n", dac_sync_n, 1);
    check("abort_sclk", dac_sclk, 0);
    check("abort_sdin", dac_sdin, 0);
    check("abort_ready", ready, 1);
    step(2);
    reset = 1'b0;
    step(150);
    check("abort_no_frame", frame_cnt, base);
    check("abort_idle_ready", ready, 1);

`ifndef AD5791_SKIP_UNCHANGED_EN
    // Data registers cleared by reset
    mode = 1'b0;
    base = frame_cnt;
    wait_frames(base + 1, "post_rst");
    check_words("post_rst", 24'h100000, 24'h100000, 24'h100000, 24'h100000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
